// File: rtl/controller_pkg.sv
// Shared definitions for the multicycle controller and its data path:
// state encodings, instruction field constants, ALU codes and mux selects.
package controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_READ = 4'd3,
    S_LW_WB    = 4'd4,
    S_SW       = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_JAL      = 4'd10,
    S_JR       = 4'd11,
    S_I_EXEC   = 4'd12,
    S_I_WB     = 4'd13
  } state_t;

  // Which rule the ALU decoder applies in the current state.
  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_ADD  = 3'd1,
    CLS_SUB  = 3'd2,
    CLS_R    = 3'd3,
    CLS_I    = 3'd4
  } alu_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REGA   = 2'b11;

  // Dispatch from DECODE; unknown opcodes fall back to FETCH as a NOP.
  function automatic state_t decode_next(input logic [5:0] opcode, input logic [5:0] func);
    case (opcode)
      OP_LW, OP_SW:               return S_MEM_ADDR;
      OP_RTYPE:                   return (func == FN_JR) ? S_JR : S_R_EXEC;
      OP_BEQ, OP_BNE:             return S_BRANCH;
      OP_J:                       return S_JUMP;
      OP_JAL:                     return S_JAL;
      OP_ADDI, OP_SLTI, OP_ANDI:  return S_I_EXEC;
      default:                    return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/controller_if.sv
// Control bus between the controller (master) and the data path (slave).
interface controller_if;
  import controller_pkg::*;

  logic       ZERO;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       pc_write;
  logic       IR_write;
  logic       reg_write;
  logic       mem_write;
  logic       mem_read;
  logic       reg_dst;
  logic       jal_reg;
  logic       pc_to_reg;
  logic       mem_to_reg;
  logic       alu_src_A;
  logic [1:0] alu_src_B;
  logic [1:0] pc_src;
  logic       I_or_D;
  logic [2:0] alu_op;

  modport master (
    input  ZERO, opcode, func,
    output pc_write, IR_write, reg_write, mem_write, mem_read, reg_dst, jal_reg,
           pc_to_reg, mem_to_reg, alu_src_A, alu_src_B, pc_src, I_or_D, alu_op
  );

  modport slave (
    output ZERO, opcode, func,
    input  pc_write, IR_write, reg_write, mem_write, mem_read, reg_dst, jal_reg,
           pc_to_reg, mem_to_reg, alu_src_A, alu_src_B, pc_src, I_or_D, alu_op
  );

endinterface

// File: rtl/controller_alu_decode.sv
// Maps the current state class plus opcode/func to the ALU function code.
module controller_alu_decode
  import controller_pkg::*;
(
  input  alu_class_t alu_class,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic [2:0] alu_op
);

  // Pure table lookup; unrecognised func/opcode values default to add.
  always_comb begin
    alu_op = ALU_AND;
    case (alu_class)
      CLS_ADD: alu_op = ALU_ADD;
      CLS_SUB: alu_op = ALU_SUB;
      CLS_R: begin
        case (func)
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      CLS_I: begin
        case (opcode)
          OP_SLTI: alu_op = ALU_SLT;
          OP_ANDI: alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Multicycle Moore controller for the MIPS-style data path.
//
// state    | meaning
// FETCH    | read instruction at PC, load IR, PC <= PC + 4
// DECODE   | dispatch on opcode, precompute branch target
// MEM_ADDR | ALUOut <= A + sign-extended imm (lw/sw)
// MEM_READ | read memory at ALUOut into MDR
// LW_WB    | rt <= MDR
// SW       | memory at ALUOut <= B
// R_EXEC   | ALUOut <= A op B
// R_WB     | rd <= ALUOut
// BRANCH   | compare A and B, conditionally load branch target
// JUMP     | PC <= {PC[31:28], target, 00}
// JAL      | jump and r31 <= PC (already incremented)
// JR       | PC <= A
// I_EXEC   | ALUOut <= A op imm
// I_WB     | rt <= ALUOut
module controller
  import controller_pkg::*;
(
  input logic        clk,
  input logic        rst,
  controller_if.master bus
);

  state_t     state;
  state_t     state_next;
  alu_class_t alu_class;

  // State register; a low rst at the edge restarts at FETCH.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_next;
  end

  // Next state and Moore outputs; everything is held low while rst is low.
  always_comb begin
    state_next     = S_FETCH;
    alu_class      = CLS_NONE;
    bus.pc_write   = 1'b0;
    bus.IR_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.jal_reg    = 1'b0;
    bus.pc_to_reg  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_A  = 1'b0;
    bus.alu_src_B  = SRC_B_REG;
    bus.pc_src     = PC_SRC_ALU;
    bus.I_or_D     = 1'b0;
    case (state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.IR_write  = 1'b1;
        bus.pc_write  = 1'b1;
        bus.alu_src_B = SRC_B_FOUR;
        alu_class     = CLS_ADD;
        state_next    = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_B = SRC_B_IMM_SH;
        alu_class     = CLS_ADD;
        state_next    = decode_next(bus.opcode, bus.func);
      end
      S_MEM_ADDR: begin
        bus.alu_src_A = 1'b1;
        bus.alu_src_B = SRC_B_IMM;
        alu_class     = CLS_ADD;
        state_next    = (bus.opcode == OP_SW) ? S_SW : S_MEM_READ;
      end
      S_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.I_or_D   = 1'b1;
        state_next   = S_LW_WB;
      end
      S_LW_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_SW: begin
        bus.mem_write = 1'b1;
        bus.I_or_D    = 1'b1;
      end
      S_R_EXEC: begin
        bus.alu_src_A = 1'b1;
        alu_class     = CLS_R;
        state_next    = S_R_WB;
      end
      S_R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_A = 1'b1;
        bus.pc_src    = PC_SRC_ALUOUT;
        alu_class     = CLS_SUB;
        bus.pc_write  = (bus.opcode == OP_BNE) ? ~bus.ZERO : bus.ZERO;
      end
      S_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = PC_SRC_JUMP;
      end
      S_JAL: begin
        bus.pc_write  = 1'b1;
        bus.pc_src    = PC_SRC_JUMP;
        bus.reg_write = 1'b1;
        bus.jal_reg   = 1'b1;
        bus.pc_to_reg = 1'b1;
      end
      S_JR: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = PC_SRC_REGA;
      end
      S_I_EXEC: begin
        bus.alu_src_A = 1'b1;
        bus.alu_src_B = SRC_B_IMM;
        alu_class     = CLS_I;
        state_next    = S_I_WB;
      end
      S_I_WB: begin
        bus.reg_write = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
    if (!rst) begin
      alu_class      = CLS_NONE;
      bus.pc_write   = 1'b0;
      bus.IR_write   = 1'b0;
      bus.reg_write  = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_read   = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.jal_reg    = 1'b0;
      bus.pc_to_reg  = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.alu_src_A  = 1'b0;
      bus.alu_src_B  = SRC_B_REG;
      bus.pc_src     = PC_SRC_ALU;
      bus.I_or_D     = 1'b0;
    end
  end

  controller_alu_decode u_alu_decode (
    .alu_class (alu_class),
    .opcode    (bus.opcode),
    .func      (bus.func),
    .alu_op    (bus.alu_op)
  );

endmodule

// File: tb/tb_controller.sv
// Directed self-checking bench for the multicycle controller.
module tb_controller;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  controller_if bus ();

  controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout (18 bits):
  // pc_write IR_write reg_write mem_write mem_read _ reg_dst jal_reg pc_to_reg mem_to_reg
  // _ alu_src_A _ alu_src_B[1:0] _ pc_src[1:0] _ I_or_D _ alu_op[2:0]
  localparam logic [17:0] E_ZERO     = 18'b00000_0000_0_00_00_0_000;
  localparam logic [17:0] E_FETCH    = 18'b11001_0000_0_01_00_0_010;
  localparam logic [17:0] E_DECODE   = 18'b00000_0000_0_11_00_0_010;
  localparam logic [17:0] E_MEM_ADDR = 18'b00000_0000_1_10_00_0_010;
  localparam logic [17:0] E_MEM_READ = 18'b00001_0000_0_00_00_1_000;
  localparam logic [17:0] E_LW_WB    = 18'b00100_0001_0_00_00_0_000;
  localparam logic [17:0] E_SW       = 18'b00010_0000_0_00_00_1_000;
  localparam logic [17:0] E_R_SUB    = 18'b00000_0000_1_00_00_0_110;
  localparam logic [17:0] E_R_WB     = 18'b00100_1000_0_00_00_0_000;
  localparam logic [17:0] E_BR_TAKEN = 18'b10000_0000_1_00_01_0_110;
  localparam logic [17:0] E_BR_NOT   = 18'b00000_0000_1_00_01_0_110;
  localparam logic [17:0] E_JUMP     = 18'b10000_0000_0_00_10_0_000;
  localparam logic [17:0] E_JAL      = 18'b10100_0110_0_00_10_0_000;
  localparam logic [17:0] E_JR       = 18'b10000_0000_0_00_11_0_000;
  localparam logic [17:0] E_I_WB     = 18'b00100_0000_0_00_00_0_000;

  function automatic logic [17:0] got();
    return {bus.pc_write, bus.IR_write, bus.reg_write, bus.mem_write, bus.mem_read,
            bus.reg_dst, bus.jal_reg, bus.pc_to_reg, bus.mem_to_reg, bus.alu_src_A,
            bus.alu_src_B, bus.pc_src, bus.I_or_D, bus.alu_op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      if (got() !== E_ZERO) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: got %b expected %b", i, got(), E_ZERO);
      end
      n_cmp++;
      if (i < 2) tick();
    end
    rst = 1'b1;
    #1;
    if (got() !== E_FETCH) begin
      n_err++;
      $display("FAIL reset_release: got %b expected %b", got(), E_FETCH);
    end
    n_cmp++;
  endtask

  task automatic test_r_type();
    logic [17:0] e [$] = '{E_FETCH, E_DECODE, E_R_SUB, E_R_WB};
    bus.opcode = 6'b000000;
    bus.func   = 6'b100010;
    for (int i = 0; i < e.size(); i++) begin
      #1;
      if (got() !== e[i]) begin
        n_err++;
        $display("FAIL r_sub cyc%0d: got %b expected %b", i, got(), e[i]);
      end
      n_cmp++;
      tick();
    end
  endtask

  task automatic test_r_alu_ops();
    logic [5:0] fn [5] = '{6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    logic [2:0] op [5] = '{3'b010, 3'b000, 3'b001, 3'b111, 3'b010};
    logic [17:0] exp_v;
    for (int k = 0; k < 5; k++) begin
      bus.opcode = 6'b000000;
      bus.func   = fn[k];
      exp_v      = {15'b00000_0000_1_00_00_0, op[k]};
      tick();
      tick();
      #1;
      if (got() !== exp_v) begin
        n_err++;
        $display("FAIL r_alu func=%b: got %b expected %b", fn[k], got(), exp_v);
      end
      n_cmp++;
      tick();
      tick();
    end
  endtask

  task automatic test_lw();
    logic [17:0] e [$] = '{E_FETCH, E_DECODE, E_MEM_ADDR, E_MEM_READ, E_LW_WB};
    bus.opcode = 6'b100011;
    bus.func   = 6'b000000;
    for (int i = 0; i < e.size(); i++) begin
      #1;
      if (got() !== e[i]) begin
        n_err++;
        $display("FAIL lw cyc%0d: got %b expected %b", i, got(), e[i]);
      end
      n_cmp++;
      tick();
    end
  endtask

  task automatic test_sw();
    logic [17:0] e [$] = '{E_FETCH, E_DECODE, E_MEM_ADDR, E_SW};
    bus.opcode = 6'b101011;
    bus.func   = 6'b000000;
    for (int i = 0; i < e.size(); i++) begin
      #1;
      if (got() !== e[i]) begin
        n_err++;
        $display("FAIL sw cyc%0d: got %b expected %b", i, got(), e[i]);
      end
      n_cmp++;
      tick();
    end
  endtask

  task automatic test_branch(input logic [5:0] opc, input logic z, input logic [17:0] e_br);
    logic [17:0] e [$];
    e = '{E_FETCH, E_DECODE, e_br};
    bus.opcode = opc;
    bus.func   = 6'b000000;
    bus.ZERO   = z;
    for (int i = 0; i < e.size(); i++) begin
      #1;
      if (got() !== e[i]) begin
        n_err++;
        $display("FAIL branch op=%b zero=%b cyc%0d: got %b expected %b", opc, z, i, got(), e[i]);
      end
      n_cmp++;
      tick();
    end
    bus.ZERO = 1'b0;
  endtask

  task automatic test_branch_zero_live();
    bus.opcode = 6'b000100;
    bus.ZERO   = 1'b0;
    tick();
    tick();
    bus.ZERO = 1'b1;
    #1;
    if (bus.pc_write !== 1'b1) begin
      n_err++;
      $display("FAIL beq_live zero=1: got pc_write=%b expected 1", bus.pc_write);
    end
    n_cmp++;
    bus.ZERO = 1'b0;
    #1;
    if (bus.pc_write !== 1'b0) begin
      n_err++;
      $display("FAIL beq_live zero=0: got pc_write=%b expected 0", bus.pc_write);
    end
    n_cmp++;
    tick();
  endtask

  task automatic test_jumps();
    logic [5:0]  opc [3] = '{6'b000010, 6'b000011, 6'b000000};
    logic [5:0]  fn  [3] = '{6'b000000, 6'b000000, 6'b001000};
    logic [17:0] ex  [3] = '{E_JUMP, E_JAL, E_JR};
    logic [17:0] e [$];
    for (int k = 0; k < 3; k++) begin
      bus.opcode = opc[k];
      bus.func   = fn[k];
      e = '{E_FETCH, E_DECODE, ex[k]};
      for (int i = 0; i < e.size(); i++) begin
        #1;
        if (got() !== e[i]) begin
          n_err++;
          $display("FAIL jump op=%b cyc%0d: got %b expected %b", opc[k], i, got(), e[i]);
        end
        n_cmp++;
        tick();
      end
    end
  endtask

  task automatic test_i_type();
    logic [5:0] opc [3] = '{6'b001000, 6'b001010, 6'b001100};
    logic [2:0] op  [3] = '{3'b010, 3'b111, 3'b000};
    logic [17:0] e [$];
    for (int k = 0; k < 3; k++) begin
      bus.opcode = opc[k];
      bus.func   = 6'b100010;
      e = '{E_FETCH, E_DECODE, {15'b00000_0000_1_10_00_0, op[k]}, E_I_WB};
      for (int i = 0; i < e.size(); i++) begin
        #1;
        if (got() !== e[i]) begin
          n_err++;
          $display("FAIL itype op=%b cyc%0d: got %b expected %b", opc[k], i, got(), e[i]);
        end
        n_cmp++;
        tick();
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [17:0] e [$] = '{E_FETCH, E_DECODE, E_MEM_ADDR};
    bus.opcode = 6'b100011;
    for (int i = 0; i < e.size(); i++) begin
      #1;
      if (got() !== e[i]) begin
        n_err++;
        $display("FAIL midrst pre cyc%0d: got %b expected %b", i, got(), e[i]);
      end
      n_cmp++;
      if (i < 2) tick();
    end
    rst = 1'b0;
    #1;
    if (got() !== E_ZERO) begin
      n_err++;
      $display("FAIL midrst asserted: got %b expected %b", got(), E_ZERO);
    end
    n_cmp++;
    tick();
    rst = 1'b1;
    #1;
    if (got() !== E_FETCH) begin
      n_err++;
      $display("FAIL midrst release: got %b expected %b", got(), E_FETCH);
    end
    n_cmp++;
    e = '{E_FETCH, E_DECODE, E_MEM_ADDR, E_MEM_READ, E_LW_WB};
    for (int i = 0; i < e.size(); i++) begin
      #1;
      if (got() !== e[i]) begin
        n_err++;
        $display("FAIL midrst rerun cyc%0d: got %b expected %b", i, got(), e[i]);
      end
      n_cmp++;
      tick();
    end
  endtask

  task automatic test_nop();
    logic [17:0] e [$] = '{E_FETCH, E_DECODE, E_FETCH};
    bus.opcode = 6'b111111;
    bus.func   = 6'b000000;
    for (int i = 0; i < e.size(); i++) begin
      #1;
      if (got() !== e[i]) begin
        n_err++;
        $display("FAIL nop cyc%0d: got %b expected %b", i, got(), e[i]);
      end
      n_cmp++;
      tick();
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b0;
    bus.ZERO   = 1'b0;
    bus.opcode = 6'b000000;
    bus.func   = 6'b000000;
    test_reset();
    test_r_type();
    test_r_alu_ops();
    test_lw();
    test_sw();
    test_branch(6'b000100, 1'b1, E_BR_TAKEN);
    test_branch(6'b000100, 1'b0, E_BR_NOT);
    test_branch(6'b000101, 1'b0, E_BR_TAKEN);
    test_branch(6'b000101, 1'b1, E_BR_NOT);
    test_branch_zero_live();
    test_jumps();
    test_i_type();
    test_mid_reset();
    test_nop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
